baccarat_round: RTL and testbench

BACCARAT_ROUND -- requirements
Module: baccarat_round

---
 rtl/baccarat_round.sv | 147 ++++++++++++++
 tb/tb_baccarat_round.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/baccarat_round.sv
// ---------------------------------------------------------------------------
// baccarat_round
// Plays one round of punto banco baccarat. Cards come from an upstream dealer
// one per accepted step; the block places each card in the player or banker
// slot, applies the tableau rules for the third cards and flags the winner.
//
// Ports
//   clock              rising-edge clock
//   reset              synchronous active-high reset, beats every other input
//   new_card[3:0]      raw card rank from the dealer (1..13)
//   step               deal request; one card is taken per sampled-high cycle
//   pcard1..3[3:0]     player card slots, raw rank, 0 when not dealt
//   dcard1..3[3:0]     banker card slots, raw rank, 0 when not dealt
//   pscore,dscore[3:0] hand scores 0..9, combinational from the slots
//   player_win         high in S_DONE when pscore >= dscore
//   dealer_win         high in S_DONE when dscore >= pscore
//   done               high while the round is finished (sticky until reset)
// ---------------------------------------------------------------------------
module baccarat_round (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] new_card,
  input  logic       step,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic       player_win,
  output logic       dealer_win,
  output logic       done
);

  typedef enum logic [3:0] {
    S_P1    = 4'd0,
    S_D1    = 4'd1,
    S_P2    = 4'd2,
    S_D2    = 4'd3,
    S_EVAL1 = 4'd4,
    S_P3    = 4'd5,
    S_EVAL2 = 4'd6,
    S_D3    = 4'd7,
    S_DONE  = 4'd8
  } state_t;

  state_t state, state_next;

  // Face cards, tens and illegal codes all count as zero.
  function automatic logic [3:0] card_value(input logic [3:0] c);
    return ((c >= 4'd1) && (c <= 4'd9)) ? c : 4'd0;
  endfunction

  // Three values of at most 9 sum to at most 27, so two conditional
  // subtractions are enough for the mod-10 reduction.
  function automatic logic [3:0] hand_score(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic [3:0] c);
    logic [4:0] sum;
    logic [4:0] red;
    sum = {1'b0, card_value(a)} + {1'b0, card_value(b)} + {1'b0, card_value(c)};
    if (sum >= 5'd20)      red = sum - 5'd20;
    else if (sum >= 5'd10) red = sum - 5'd10;
    else                   red = sum;
    return red[3:0];
  endfunction

  assign pscore = hand_score(pcard1, pcard2, pcard3);
  assign dscore = hand_score(dcard1, dcard2, dcard3);

  // Banker third-card rule, keyed on the value of the player's third card.
  logic [3:0] p3_value;
  logic       banker_draws;

  assign p3_value = card_value(pcard3);

  always_comb begin
    banker_draws = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
      4'd3:             banker_draws = (p3_value != 4'd8);
      4'd4:             banker_draws = (p3_value >= 4'd2) && (p3_value <= 4'd7);
      4'd5:             banker_draws = (p3_value >= 4'd4) && (p3_value <= 4'd7);
      4'd6:             banker_draws = (p3_value >= 4'd6) && (p3_value <= 4'd7);
      default:          banker_draws = 1'b0;
    endcase
  end

  // Next-state logic. Deal states advance only on step; the evaluation states
  // are single-cycle decisions that never consume a card.
  always_comb begin
    state_next = state;
    case (state)
      S_P1:    if (step) state_next = S_D1;
      S_D1:    if (step) state_next = S_P2;
      S_P2:    if (step) state_next = S_D2;
      S_D2:    if (step) state_next = S_EVAL1;
      S_EVAL1: begin
        if ((pscore >= 4'd8) || (dscore >= 4'd8)) state_next = S_DONE;
        else if (pscore <= 4'd5)                  state_next = S_P3;
        else if (dscore <= 4'd5)                  state_next = S_D3;
        else                                      state_next = S_DONE;
      end
      S_P3:    if (step) state_next = S_EVAL2;
      S_EVAL2: state_next = banker_draws ? S_D3 : S_DONE;
      S_D3:    if (step) state_next = S_DONE;
      S_DONE:  state_next = S_DONE;
      default: state_next = S_P1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_P1;
    else       state <= state_next;
  end

  // Card slots: each one loads only in its own deal state on an accepted step.
  always_ff @(posedge clock) begin
    if (reset) begin
      pcard1 <= 4'd0;
      pcard2 <= 4'd0;
      pcard3 <= 4'd0;
      dcard1 <= 4'd0;
      dcard2 <= 4'd0;
      dcard3 <= 4'd0;
    end else if (step) begin
      case (state)
        S_P1:    pcard1 <= new_card;
        S_D1:    dcard1 <= new_card;
        S_P2:    pcard2 <= new_card;
        S_D2:    dcard2 <= new_card;
        S_P3:    pcard3 <= new_card;
        S_D3:    dcard3 <= new_card;
        default: ;
      endcase
    end
  end

  // Result flags are decoded from the state, so done appears on the edge that
  // enters S_DONE; a tie raises both win flags.
  assign done       = (state == S_DONE);
  assign player_win = done && (pscore >= dscore);
  assign dealer_win = done && (dscore >= pscore);

endmodule

// File: tb/tb_baccarat_round.sv
// ---------------------------------------------------------------------------
// tb_baccarat_round
// Directed rounds with hand-computed results. The driver pushes the expected
// final hand (and the cycle done must rise on) into a queue; an independent
// monitor pops it when done rises and keeps comparing while done stays high.
// ---------------------------------------------------------------------------
module tb_baccarat_round;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] new_card = 4'd0;
  logic       step = 1'b0;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore;
  logic       player_win, dealer_win, done;

  baccarat_round dut (
    .clock(clock), .reset(reset), .new_card(new_card), .step(step),
    .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
    .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
    .pscore(pscore), .dscore(dscore),
    .player_win(player_win), .dealer_win(dealer_win), .done(done)
  );

  always #5 clock = ~clock;

  int cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  typedef struct {
    logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3, ps, ds;
    logic       pw, dw;
    int         done_cycle;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic exp_t mkExp(input logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3,
                                 input logic [3:0] ps, ds, input logic pw, dw);
    exp_t e;
    e.pc1 = pc1; e.pc2 = pc2; e.pc3 = pc3;
    e.dc1 = dc1; e.dc2 = dc2; e.dc3 = dc3;
    e.ps = ps; e.ds = ds; e.pw = pw; e.dw = dw;
    e.done_cycle = 0;
    return e;
  endfunction

  task automatic compareAll(input exp_t e, input string tag);
    checkOutput({tag, "_pcard1"}, pcard1, e.pc1);
    checkOutput({tag, "_pcard2"}, pcard2, e.pc2);
    checkOutput({tag, "_pcard3"}, pcard3, e.pc3);
    checkOutput({tag, "_dcard1"}, dcard1, e.dc1);
    checkOutput({tag, "_dcard2"}, dcard2, e.dc2);
    checkOutput({tag, "_dcard3"}, dcard3, e.dc3);
    checkOutput({tag, "_pscore"}, pscore, e.ps);
    checkOutput({tag, "_dscore"}, dscore, e.ds);
    checkOutput({tag, "_player_win"}, player_win, e.pw);
    checkOutput({tag, "_dealer_win"}, dealer_win, e.dw);
  endtask

  // Monitor: pops on the rising of done, then checks the outputs stay put.
  exp_t held;
  bit   done_seen = 1'b0;
  always @(negedge clock) begin
    if (done && !done_seen) begin
      done_seen = 1'b1;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        held = exp_q.pop_front();
        checkOutput("done_cycle", cycle, held.done_cycle);
        compareAll(held, "final");
      end
    end else if (done && done_seen) begin
      compareAll(held, "sticky");
    end
    if (!done) done_seen = 1'b0;
  end

  task automatic applyStimulus(input logic s, input logic [3:0] c);
    step = s;
    new_card = c;
    @(posedge clock);
    #1;
  endtask

  task automatic pushExpected(input exp_t e);
    exp_t t;
    t = e;
    t.done_cycle = cycle + 1;
    exp_q.push_back(t);
  endtask

  // Reset with step held high and a live card: nothing may latch.
  task automatic doReset();
    reset = 1'b1;
    step = 1'b1;
    new_card = 4'd7;
    @(posedge clock);
    #1;
    reset = 1'b0;
    step = 1'b0;
    checkOutput("reset_pcard1", pcard1, 0);
    checkOutput("reset_dcard3", dcard3, 0);
    checkOutput("reset_pscore", pscore, 0);
    checkOutput("reset_dscore", dscore, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_wins", {player_win, dealer_win}, 0);
  endtask

  // Junk card 9 is offered during evaluation and after done; if it were ever
  // latched it would change a slot and a score.
  task automatic runRound(input logic [3:0] p1, d1, p2, d2, p3, d3,
                          input bit has_p3, has_d3, input exp_t e);
    doReset();
    applyStimulus(1'b1, p1);
    applyStimulus(1'b1, d1);
    applyStimulus(1'b1, p2);
    applyStimulus(1'b1, d2);
    if (!has_p3 && !has_d3) begin
      pushExpected(e);
      applyStimulus(1'b1, 4'd9);
    end else begin
      applyStimulus(1'b1, 4'd9);
      if (has_p3) begin
        applyStimulus(1'b1, p3);
        if (!has_d3) begin
          pushExpected(e);
          applyStimulus(1'b1, 4'd9);
        end else begin
          applyStimulus(1'b1, 4'd9);
          pushExpected(e);
          applyStimulus(1'b1, d3);
        end
      end else begin
        pushExpected(e);
        applyStimulus(1'b1, d3);
      end
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'd9);
    checkOutput("round_completed", exp_q.size(), 0);
    checkOutput("done_high", done, 1);
    exp_q.delete();
    step = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;

    // Natural 9 against 5.
    runRound(4'd4, 4'd2, 4'd5, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0,
             mkExp(4'd4, 4'd5, 4'd0, 4'd2, 4'd3, 4'd0, 4'd9, 4'd5, 1'b1, 1'b0));
    // Player draws to 8, banker stands on 7.
    runRound(4'd1, 4'd3, 4'd2, 4'd4, 4'd5, 4'd0, 1'b1, 1'b0,
             mkExp(4'd1, 4'd2, 4'd5, 4'd3, 4'd4, 4'd0, 4'd8, 4'd7, 1'b1, 1'b0));
    // Banker on 6 draws against a player third card of 6.
    runRound(4'd10, 4'd2, 4'd13, 4'd4, 4'd6, 4'd1, 1'b1, 1'b1,
             mkExp(4'd10, 4'd13, 4'd6, 4'd2, 4'd4, 4'd1, 4'd6, 4'd7, 1'b0, 1'b1));
    // Player stands on 6, banker draws from 2.
    runRound(4'd3, 4'd1, 4'd3, 4'd1, 4'd0, 4'd5, 1'b0, 1'b1,
             mkExp(4'd3, 4'd3, 4'd0, 4'd1, 4'd1, 4'd5, 4'd6, 4'd7, 1'b0, 1'b1));
    // Tie on naturals: both flags.
    runRound(4'd9, 4'd9, 4'd10, 4'd13, 4'd0, 4'd0, 1'b0, 1'b0,
             mkExp(4'd9, 4'd10, 4'd0, 4'd9, 4'd13, 4'd0, 4'd9, 4'd9, 1'b1, 1'b1));
    // Banker 3 stands against an 8; player total wraps to 0.
    runRound(4'd1, 4'd1, 4'd1, 4'd2, 4'd8, 4'd0, 1'b1, 1'b0,
             mkExp(4'd1, 4'd1, 4'd8, 4'd1, 4'd2, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1));
    // Banker 4 (illegal 15 counts 0) stands against a 1: tie at 4.
    runRound(4'd2, 4'd15, 4'd1, 4'd4, 4'd1, 4'd0, 1'b1, 1'b0,
             mkExp(4'd2, 4'd1, 4'd1, 4'd15, 4'd4, 4'd0, 4'd4, 4'd4, 1'b1, 1'b1));
    // Illegal 14 and 0 count 0; banker 5 draws against a 4.
    runRound(4'd14, 4'd5, 4'd0, 4'd0, 4'd4, 4'd3, 1'b1, 1'b1,
             mkExp(4'd14, 4'd0, 4'd4, 4'd5, 4'd0, 4'd3, 4'd4, 4'd8, 1'b0, 1'b1));
    // Banker 6 stands against an 8.
    runRound(4'd2, 4'd3, 4'd1, 4'd3, 4'd8, 4'd0, 1'b1, 1'b0,
             mkExp(4'd2, 4'd1, 4'd8, 4'd3, 4'd3, 4'd0, 4'd1, 4'd6, 1'b0, 1'b1));

    // Reset in the middle of a deal, then one card per cycle with step held.
    doReset();
    applyStimulus(1'b1, 4'd7);
    applyStimulus(1'b1, 4'd7);
    applyStimulus(1'b1, 4'd7);
    checkOutput("mid_pcard2", pcard2, 7);
    doReset();
    checkOutput("mid_reset_pcard2", pcard2, 0);
    checkOutput("mid_reset_dcard1", dcard1, 0);
    applyStimulus(1'b1, 4'd4);
    checkOutput("held_pcard1", pcard1, 4);
    checkOutput("held_dcard1_empty", dcard1, 0);
    applyStimulus(1'b0, 4'd9);
    checkOutput("stall_pcard1", pcard1, 4);
    checkOutput("stall_dcard1", dcard1, 0);
    applyStimulus(1'b1, 4'd2);
    checkOutput("held_dcard1", dcard1, 2);
    checkOutput("held_pcard2_empty", pcard2, 0);
    applyStimulus(1'b1, 4'd5);
    checkOutput("held_pcard2", pcard2, 5);
    applyStimulus(1'b1, 4'd3);
    checkOutput("held_dcard2", dcard2, 3);
    checkOutput("held_not_done", done, 0);
    pushExpected(mkExp(4'd4, 4'd5, 4'd0, 4'd2, 4'd3, 4'd0, 4'd9, 4'd5, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'd9);
    checkOutput("held_round_completed", exp_q.size(), 0);
    exp_q.delete();
    step = 1'b0;

    // Reset out of S_DONE clears the flags.
    doReset();

    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
